// File: rtl/eth_stats_fifo_reader.sv
// AXI4-Lite master that drains the stats collector FIFO: polls occupancy, pops an
// entry, reads its 14 words and delivers them as one 448-bit sample.
module eth_stats_fifo_reader #(
  parameter logic [11:0] base_addr = 12'h000,
  parameter int unsigned poll_gap  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [11:0]  m_axi_awaddr,
  output logic [2:0]   m_axi_awprot,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [31:0]  m_axi_wdata,
  output logic [3:0]   m_axi_wstrb,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic [11:0]  m_axi_araddr,
  output logic [2:0]   m_axi_arprot,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [31:0]  m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  output logic [447:0] sample_data,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         busy,
  output logic         error,
  output logic [31:0]  sample_count
);

  typedef enum logic [3:0] {
    IDLE, OCC_AR, OCC_R, POP_AW, POP_B, DAT_AR, DAT_R, OUT, GAP
  } state_t;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [11:0] OCC_ADDR  = base_addr + 12'h004;
  localparam logic [11:0] POP_ADDR  = base_addr + 12'h008;
  localparam logic [11:0] DATA_ADDR = base_addr + 12'h010;
  localparam logic [15:0] GAP_LAST  = 16'(poll_gap - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  idx_nxt;
  logic [15:0] gap_cnt;
  logic [8:0]  word_lsb;

  assign m_axi_awaddr = POP_ADDR;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = 32'd1;
  assign m_axi_wstrb  = 4'hF;

  // Words arrive low half first, fields time..rx_bad; time occupies the MSBs.
  always_comb begin
    idx_nxt  = idx + 4'd1;
    word_lsb = 9'd384 - {idx[3:1], 6'd0} + {3'd0, idx[0], 5'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      gap_cnt       <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      sample_count  <= '0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && !error) begin
          m_axi_araddr  <= OCC_ADDR;
          m_axi_arvalid <= 1'b1;
          busy          <= 1'b1;
          state         <= OCC_AR;
        end
        OCC_AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= OCC_R;
        end
        OCC_R: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          if (m_axi_rresp != RESP_OKAY) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (m_axi_rdata[15:0] == 16'd0) begin
            gap_cnt <= GAP_LAST;
            state   <= GAP;
          end else begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= POP_AW;
          end
        end
        POP_AW: begin
          // A channel whose valid is already low has finished its handshake.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((m_axi_awready || !m_axi_awvalid) && (m_axi_wready || !m_axi_wvalid)) begin
            m_axi_bready <= 1'b1;
            state        <= POP_B;
          end
        end
        POP_B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          if (m_axi_bresp == RESP_OKAY) begin
            idx           <= '0;
            m_axi_araddr  <= DATA_ADDR;
            m_axi_arvalid <= 1'b1;
            state         <= DAT_AR;
          end else begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DAT_AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= DAT_R;
        end
        DAT_R: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          if (m_axi_rresp != RESP_OKAY) begin
            error       <= 1'b1;
            sample_data <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            sample_data[word_lsb +: 32] <= m_axi_rdata;
            if (idx == 4'd13) begin
              sample_valid <= 1'b1;
              state        <= OUT;
            end else begin
              idx           <= idx_nxt;
              m_axi_araddr  <= DATA_ADDR + {6'd0, idx_nxt, 2'b00};
              m_axi_arvalid <= 1'b1;
              state         <= DAT_AR;
            end
          end
        end
        OUT: if (sample_ready) begin
          sample_valid <= 1'b0;
          sample_count <= sample_count + 32'd1;
          if (enable) begin
            m_axi_araddr  <= OCC_ADDR;
            m_axi_arvalid <= 1'b1;
            state         <= OCC_AR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            if (enable) begin
              m_axi_araddr  <= OCC_ADDR;
              m_axi_arvalid <= 1'b1;
              state         <= OCC_AR;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
